// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: checker state encoding
// and the default LFSR shape (x^8+x^6+x^5+x^4+1).
package prbs_pkg;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int                    PRBS_WIDTH = 8;
  localparam logic [PRBS_WIDTH-1:0] PRBS_TAPS  = 8'hB8;

endpackage

// File: rtl/lfsr_predict.sv
// Fibonacci LFSR next-bit function, shared by the PRBS generator and checker.
// sr bit 0 holds the newest bit; the next bit is the parity of the tapped bits.
module lfsr_predict
  import prbs_pkg::*;
#(
  parameter int               WIDTH = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = PRBS_TAPS
) (
  input  logic [WIDTH-1:0] sr,
  output logic             pred
);

  assign pred = ^(sr & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds from the stream, locks, counts bit errors.
// Optional err_sticky output is enabled by defining PRBS_CHK_STICKY_ERR_EN.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH     = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS      = PRBS_TAPS,
  parameter int               LOCK_CNT  = 16,
  parameter int               ERR_LIMIT = 4,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_CHK_STICKY_ERR_EN
  ,
  output logic             err_sticky
`endif
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [FW-1:0]    fill_cnt;
  logic [MW-1:0]    match_cnt;
  logic [EW-1:0]    run_cnt;
  logic             pred;
  logic             miss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  lfsr_predict #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_pred (
    .sr   (sr),
    .pred (pred)
  );

  assign miss = din ^ pred;

  // Stage p0 -> registered state and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      run_cnt   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clr_cnt) err_cnt <= '0;
      if (din_valid) begin
        sr <= {sr[WIDTH-2:0], din};
        case (state)
          SEARCH: begin
            if (fill_cnt == FILL_LAST) begin
              state     <= CHECK;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + FW'(1);
            end
          end
          CHECK: begin
            // An all-zero register predicts zeros forever; never count those as matches.
            if (miss) begin
              match_cnt <= '0;
            end else if (sr != '0) begin
              if (match_cnt == LOCK_LAST) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                run_cnt   <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end
          end
          LOCKED: begin
            if (miss) begin
              err_pulse <= 1'b1;
              if (!clr_cnt) err_cnt <= sat_inc(err_cnt);
              if (run_cnt == ERR_LAST) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                fill_cnt <= '0;
                run_cnt  <= '0;
              end else begin
                run_cnt <= run_cnt + EW'(1);
              end
            end else begin
              run_cnt <= '0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PRBS_CHK_STICKY_ERR_EN
  logic sticky_set;

  // Every loss of lock is caused by a locked misprediction, so one term covers both.
  assign sticky_set = din_valid && (state == LOCKED) && miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sticky <= 1'b0;
    else        err_sticky <= sticky_set | (err_sticky & ~clr_cnt);
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a default instance and a CNT_W=4/ERR_LIMIT=100 instance
// share one stimulus stream; a reference model feeds a scoreboard of expected outputs.
module tb_prbs_checker;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam int LIM  [2] = '{4, 100};
  localparam int CMAX [2] = '{65535, 15};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked0, pulse0, locked1, pulse1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic        sticky0, sticky1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        locked0;
    logic        pulse0;
    logic [15:0] cnt0;
    logic        sticky0;
    logic        locked1;
    logic        pulse1;
    logic [3:0]  cnt1;
    logic        sticky1;
  } exp_t;

  exp_t sbq[$];

  // Reference model state, one set per instance
  logic [7:0] m_sr     [2];
  int         m_state  [2];
  int         m_fill   [2];
  int         m_match  [2];
  int         m_run    [2];
  int         m_cnt    [2];
  logic       m_pulse  [2];
  logic       m_sticky [2];

  logic [7:0] g_sr;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked0),
    .err_pulse (pulse0),
    .err_cnt   (cnt0)
`ifdef PRBS_CHK_STICKY_ERR_EN
    ,
    .err_sticky (sticky0)
`endif
  );

  prbs_checker #(
    .CNT_W     (4),
    .ERR_LIMIT (100)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked1),
    .err_pulse (pulse1),
    .err_cnt   (cnt1)
`ifdef PRBS_CHK_STICKY_ERR_EN
    ,
    .err_sticky (sticky1)
`endif
  );

`ifndef PRBS_CHK_STICKY_ERR_EN
  assign sticky0 = 1'b0;
  assign sticky1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sr[k] = 8'h00; m_state[k] = 0; m_fill[k] = 0; m_match[k] = 0;
      m_run[k] = 0; m_cnt[k] = 0; m_pulse[k] = 1'b0; m_sticky[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic v, input logic d, input logic c);
    logic p;
    m_pulse[k] = 1'b0;
    if (v) begin
      p = ^(m_sr[k] & TAPS);
      case (m_state[k])
        0: begin
          m_fill[k]++;
          if (m_fill[k] == 8) begin m_state[k] = 1; m_match[k] = 0; end
        end
        1: begin
          if (d != p) m_match[k] = 0;
          else if (m_sr[k] != 8'h00) begin
            m_match[k]++;
            if (m_match[k] == 16) begin m_state[k] = 2; m_run[k] = 0; end
          end
        end
        default: begin
          if (d != p) begin
            m_pulse[k] = 1'b1;
            if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
            m_run[k]++;
            if (m_run[k] == LIM[k]) begin m_state[k] = 0; m_fill[k] = 0; m_run[k] = 0; end
          end else begin
            m_run[k] = 0;
          end
        end
      endcase
      m_sr[k] = {m_sr[k][6:0], d};
    end
    if (c) m_cnt[k] = 0;
    m_sticky[k] = m_pulse[k] | (m_sticky[k] & ~c);
  endtask

  function automatic logic gen_bit();
    logic b;
    b = ^(g_sr & TAPS);
    g_sr = {g_sr[6:0], b};
    return b;
  endfunction

  function automatic logic model_pred();
    return ^(m_sr[0] & TAPS);
  endfunction

  task automatic step(input logic v, input logic d, input logic c);
    exp_t e;
    exp_t got;
    @(negedge clk);
    din_valid = v; din = d; clr_cnt = c;
    model_step(0, v, d, c);
    model_step(1, v, d, c);
    e.locked0 = (m_state[0] == 2); e.pulse0 = m_pulse[0]; e.cnt0 = 16'(m_cnt[0]);
    e.locked1 = (m_state[1] == 2); e.pulse1 = m_pulse[1]; e.cnt1 = 4'(m_cnt[1]);
`ifdef PRBS_CHK_STICKY_ERR_EN
    e.sticky0 = m_sticky[0]; e.sticky1 = m_sticky[1];
`else
    e.sticky0 = 1'b0; e.sticky1 = 1'b0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check("sb_locked",     32'(locked0), 32'(got.locked0));
    check("sb_err_pulse",  32'(pulse0),  32'(got.pulse0));
    check("sb_err_cnt",    32'(cnt0),    32'(got.cnt0));
    check("sb_locked_s",   32'(locked1), 32'(got.locked1));
    check("sb_err_pulse_s",32'(pulse1),  32'(got.pulse1));
    check("sb_err_cnt_s",  32'(cnt1),    32'(got.cnt1));
`ifdef PRBS_CHK_STICKY_ERR_EN
    check("sb_sticky",     32'(sticky0), 32'(got.sticky0));
    check("sb_sticky_s",   32'(sticky1), 32'(got.sticky1));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"},  32'(locked0), 32'd0);
    check({tag, "_pulse"},   32'(pulse0),  32'd0);
    check({tag, "_cnt"},     32'(cnt0),    32'd0);
    check({tag, "_locked_s"},32'(locked1), 32'd0);
    check({tag, "_cnt_s"},   32'(cnt1),    32'd0);
`ifdef PRBS_CHK_STICKY_ERR_EN
    check({tag, "_sticky"},  32'(sticky0), 32'd0);
`endif
  endtask

  task automatic clean_bits(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      step(1'b1, gen_bit(), 1'b0);
      if (i == 23) check({tag, "_unlocked_23"}, 32'(locked0), 32'd0);
      if (i == 24) check({tag, "_locked_24"},   32'(locked0), 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    model_reset();
    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Lock acquisition from seed 8'h01
    g_sr = 8'h01;
    clean_bits(24, "acq");
    check("acq_err_cnt", 32'(cnt0), 32'd0);

    // Single error injection
    clean_bits(4, "pre_inj");
    b = gen_bit();
    step(1'b1, ~b, 1'b0);
    check("inj_pulse",  32'(pulse0),  32'd1);
    check("inj_cnt",    32'(cnt0),    32'd1);
    check("inj_locked", 32'(locked0), 32'd1);
    step(1'b1, gen_bit(), 1'b0);
    check("inj_pulse_drop", 32'(pulse0), 32'd0);
    clean_bits(11, "post_inj");
    check("inj_total_cnt", 32'(cnt0),    32'd5);
    check("inj_still_lock",32'(locked0), 32'd1);

    // Loss of lock: clear, then four forced mispredictions
    step(1'b0, 1'b0, 1'b1);
    check("clr_cnt", 32'(cnt0), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, ~model_pred(), 1'b0);
      if (i == 3) check("lol_still_locked", 32'(locked0), 32'd1);
    end
    check("lol_unlocked", 32'(locked0), 32'd0);
    check("lol_cnt",      32'(cnt0),    32'd4);
    clean_bits(24, "relock");

    // Gapped valid from a fresh reset
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    g_sr = 8'h01;
    for (int i = 1; i <= 48; i++) begin
      if (i % 2 == 1) step(1'b1, gen_bit(), 1'b0);
      else            step(1'b0, 1'b1, 1'b0);
      if (i == 46) check("gap_unlocked_46", 32'(locked0), 32'd0);
      if (i == 47) check("gap_locked_47",   32'(locked0), 32'd1);
      if (i == 48) check("gap_locked_48",   32'(locked0), 32'd1);
    end

    // Saturation on the 4-bit counter, then clear against a simultaneous error
    for (int n = 0; n < 20; n++) begin
      b = gen_bit();
      step(1'b1, ~b, 1'b0);
      clean_bits(11, "sat");
    end
    check("sat_cnt_s",    32'(cnt1),    32'hF);
    check("sat_locked_s", 32'(locked1), 32'd1);
    b = gen_bit();
    step(1'b1, ~b, 1'b1);
    check("clr_win_cnt_s",   32'(cnt1),   32'd0);
    check("clr_win_pulse_s", 32'(pulse1), 32'd1);
    check("clr_win_cnt",     32'(cnt0),   32'd0);
    check("clr_win_pulse",   32'(pulse0), 32'd1);

    // Asynchronous reset between clock edges while locked
    clean_bits(12, "pre_rst");
    b = gen_bit();
    step(1'b1, ~b, 1'b0);
    check("pre_rst_pulse", 32'(pulse0), 32'd1);
    #2;
    rst_n = 1'b0; din_valid = 1'b0;
    model_reset();
    #1;
    check_zero("async_rst");
    @(negedge clk); rst_n = 1'b1;
    clean_bits(24, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
